alu_reservation_station: RTL and testbench

Holds decoded ALU/branch/jump instructions waiting for source operands, and issues them to the combinational ALU. It snoops the ALU and load/store common-data-bus broadcasts to wake up waiting operands. It selects one ready entry per cycle and drives the ALU's input side: new_calculate, op, instruction, vj, vk, pc, imm and entry. It sits between the decoder/dispatch stage and the ALU, and is flushed by the ROB on mispredict.

---
 rtl/alu_reservation_station_pkg.sv | 57 +++++
 rtl/alu_reservation_station_find.sv | 23 ++
 rtl/alu_reservation_station.sv | 163 ++++++++++++++++
 tb/tb_alu_reservation_station.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_reservation_station_pkg.sv
// Shared definitions for the ALU reservation station: sizing, ALU op encodings
// and the per-entry storage record.
package alu_reservation_station_pkg;

  localparam int RS_SIZE  = 16;
  localparam int RS_IDX_W = 4;
  localparam int TAG_W    = 4;

  typedef enum logic [5:0] {
    OP_NOP   = 6'd0,
    OP_LUI   = 6'd1,
    OP_AUIPC = 6'd2,
    OP_JAL   = 6'd3,
    OP_JALR  = 6'd4,
    OP_BEQ   = 6'd5,
    OP_BNE   = 6'd6,
    OP_BLT   = 6'd7,
    OP_BGE   = 6'd8,
    OP_BLTU  = 6'd9,
    OP_BGEU  = 6'd10,
    OP_ADDI  = 6'd19,
    OP_SLTI  = 6'd20,
    OP_SLTIU = 6'd21,
    OP_XORI  = 6'd22,
    OP_ORI   = 6'd23,
    OP_ANDI  = 6'd24,
    OP_SLLI  = 6'd25,
    OP_SRLI  = 6'd26,
    OP_SRAI  = 6'd27,
    OP_ADD   = 6'd28,
    OP_SUB   = 6'd29,
    OP_SLL   = 6'd30,
    OP_SLT   = 6'd31,
    OP_SLTU  = 6'd32,
    OP_XOR   = 6'd33,
    OP_SRL   = 6'd34,
    OP_SRA   = 6'd35,
    OP_OR    = 6'd36,
    OP_AND   = 6'd37
  } opera_t;

  // One station slot; the busy bit lives in a separate vector for the encoders.
  typedef struct packed {
    logic [5:0]       op;
    logic [31:0]      instruction;
    logic [31:0]      pc;
    logic [31:0]      imm;
    logic [TAG_W-1:0] entry;
    logic [31:0]      vj;
    logic [TAG_W-1:0] qj;
    logic             qj_busy;
    logic [31:0]      vk;
    logic [TAG_W-1:0] qk;
    logic             qk_busy;
  } rs_entry_t;

endpackage

// File: rtl/alu_reservation_station_find.sv
// Lowest-index priority encoder over an N-bit request vector.
module rs_find #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] vec,
  output logic         found,
  output logic [W-1:0] idx
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found = 1'b1;
        idx   = i[W-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_reservation_station.sv
// Reservation station in front of the ALU: holds dispatched ops until both
// operands arrive over the CDBs, then issues the lowest ready slot each cycle.
module alu_reservation_station
  import alu_reservation_station_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear,
  input  logic             dispatch_valid,
  input  logic [5:0]       dispatch_op,
  input  logic [31:0]      dispatch_instruction,
  input  logic [31:0]      dispatch_pc,
  input  logic [31:0]      dispatch_imm,
  input  logic             dispatch_qj_busy,
  input  logic [TAG_W-1:0] dispatch_qj,
  input  logic [31:0]      dispatch_vj,
  input  logic             dispatch_qk_busy,
  input  logic [TAG_W-1:0] dispatch_qk,
  input  logic [31:0]      dispatch_vk,
  input  logic [TAG_W-1:0] dispatch_entry,
  output logic             rs_full,
  input  logic             alu_broadcast,
  input  logic [31:0]      alu_result,
  input  logic [TAG_W-1:0] alu_entry,
  input  logic             lsb_broadcast,
  input  logic [31:0]      lsb_result,
  input  logic [TAG_W-1:0] lsb_entry,
  output logic             new_calculate,
  output logic [5:0]       op,
  output logic [31:0]      instruction,
  output logic [31:0]      vj,
  output logic [31:0]      vk,
  output logic [31:0]      pc,
  output logic [31:0]      imm,
  output logic [TAG_W-1:0] entry
);

  logic [RS_SIZE-1:0]  busy;
  logic [RS_SIZE-1:0]  ready_vec;
  rs_entry_t           slots [RS_SIZE];
  rs_entry_t           incoming;
  logic                free_found;
  logic                ready_found;
  logic [RS_IDX_W-1:0] free_idx;
  logic [RS_IDX_W-1:0] ready_idx;

  assign rs_full = &busy;

  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      ready_vec[i] = busy[i] && !slots[i].qj_busy && !slots[i].qk_busy;
    end
  end

  rs_find #(.N(RS_SIZE), .W(RS_IDX_W)) u_free_find (
    .vec   (~busy),
    .found (free_found),
    .idx   (free_idx)
  );

  rs_find #(.N(RS_SIZE), .W(RS_IDX_W)) u_ready_find (
    .vec   (ready_vec),
    .found (ready_found),
    .idx   (ready_idx)
  );

  // Build the slot to write, picking up any operand broadcast in this same cycle.
  always_comb begin
    incoming             = '0;
    incoming.op          = dispatch_op;
    incoming.instruction = dispatch_instruction;
    incoming.pc          = dispatch_pc;
    incoming.imm         = dispatch_imm;
    incoming.entry       = dispatch_entry;
    incoming.qj          = dispatch_qj;
    incoming.qk          = dispatch_qk;
    incoming.vj          = dispatch_vj;
    incoming.qj_busy     = dispatch_qj_busy;
    incoming.vk          = dispatch_vk;
    incoming.qk_busy     = dispatch_qk_busy;
    if (dispatch_qj_busy) begin
      if (alu_broadcast && alu_entry == dispatch_qj) begin
        incoming.vj      = alu_result;
        incoming.qj_busy = 1'b0;
      end else if (lsb_broadcast && lsb_entry == dispatch_qj) begin
        incoming.vj      = lsb_result;
        incoming.qj_busy = 1'b0;
      end
    end
    if (dispatch_qk_busy) begin
      if (alu_broadcast && alu_entry == dispatch_qk) begin
        incoming.vk      = alu_result;
        incoming.qk_busy = 1'b0;
      end else if (lsb_broadcast && lsb_entry == dispatch_qk) begin
        incoming.vk      = lsb_result;
        incoming.qk_busy = 1'b0;
      end
    end
  end

  // Free and ready searches both use pre-edge busy bits, so a slot freed by
  // issue cannot be refilled until the following cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy          <= '0;
      new_calculate <= 1'b0;
      op            <= '0;
      instruction   <= '0;
      vj            <= '0;
      vk            <= '0;
      pc            <= '0;
      imm           <= '0;
      entry         <= '0;
      for (int i = 0; i < RS_SIZE; i++) slots[i] <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        busy          <= '0;
        new_calculate <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy[i] && slots[i].qj_busy) begin
            if (alu_broadcast && alu_entry == slots[i].qj) begin
              slots[i].vj      <= alu_result;
              slots[i].qj_busy <= 1'b0;
            end else if (lsb_broadcast && lsb_entry == slots[i].qj) begin
              slots[i].vj      <= lsb_result;
              slots[i].qj_busy <= 1'b0;
            end
          end
          if (busy[i] && slots[i].qk_busy) begin
            if (alu_broadcast && alu_entry == slots[i].qk) begin
              slots[i].vk      <= alu_result;
              slots[i].qk_busy <= 1'b0;
            end else if (lsb_broadcast && lsb_entry == slots[i].qk) begin
              slots[i].vk      <= lsb_result;
              slots[i].qk_busy <= 1'b0;
            end
          end
        end
        if (ready_found) begin
          new_calculate   <= 1'b1;
          op              <= slots[ready_idx].op;
          instruction     <= slots[ready_idx].instruction;
          vj              <= slots[ready_idx].vj;
          vk              <= slots[ready_idx].vk;
          pc              <= slots[ready_idx].pc;
          imm             <= slots[ready_idx].imm;
          entry           <= slots[ready_idx].entry;
          busy[ready_idx] <= 1'b0;
        end else begin
          new_calculate <= 1'b0;
        end
        if (dispatch_valid && free_found) begin
          slots[free_idx] <= incoming;
          busy[free_idx]  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed self-checking bench for alu_reservation_station.
module tb_alu_reservation_station;
  import alu_reservation_station_pkg::*;

  logic             clk_in = 1'b0;
  logic             rst_in, rdy_in, clear;
  logic             dispatch_valid;
  logic [5:0]       dispatch_op;
  logic [31:0]      dispatch_instruction, dispatch_pc, dispatch_imm;
  logic             dispatch_qj_busy, dispatch_qk_busy;
  logic [TAG_W-1:0] dispatch_qj, dispatch_qk, dispatch_entry;
  logic [31:0]      dispatch_vj, dispatch_vk;
  logic             rs_full;
  logic             alu_broadcast, lsb_broadcast;
  logic [31:0]      alu_result, lsb_result;
  logic [TAG_W-1:0] alu_entry, lsb_entry;
  logic             new_calculate;
  logic [5:0]       op;
  logic [31:0]      instruction, vj, vk, pc, imm;
  logic [TAG_W-1:0] entry;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_in = ~clk_in;

  alu_reservation_station dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .dispatch_valid(dispatch_valid), .dispatch_op(dispatch_op),
    .dispatch_instruction(dispatch_instruction), .dispatch_pc(dispatch_pc),
    .dispatch_imm(dispatch_imm), .dispatch_qj_busy(dispatch_qj_busy),
    .dispatch_qj(dispatch_qj), .dispatch_vj(dispatch_vj),
    .dispatch_qk_busy(dispatch_qk_busy), .dispatch_qk(dispatch_qk),
    .dispatch_vk(dispatch_vk), .dispatch_entry(dispatch_entry),
    .rs_full(rs_full),
    .alu_broadcast(alu_broadcast), .alu_result(alu_result), .alu_entry(alu_entry),
    .lsb_broadcast(lsb_broadcast), .lsb_result(lsb_result), .lsb_entry(lsb_entry),
    .new_calculate(new_calculate), .op(op), .instruction(instruction),
    .vj(vj), .vk(vk), .pc(pc), .imm(imm), .entry(entry)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idleInputs();
    dispatch_valid = 1'b0;
    alu_broadcast  = 1'b0;
    lsb_broadcast  = 1'b0;
    clear          = 1'b0;
  endtask

  task automatic applyStimulus(input logic [5:0] o, input logic [31:0] ins,
                               input logic [31:0] p, input logic [31:0] im,
                               input logic qjb, input logic [TAG_W-1:0] qjt,
                               input logic [31:0] vjv, input logic qkb,
                               input logic [TAG_W-1:0] qkt, input logic [31:0] vkv,
                               input logic [TAG_W-1:0] ent);
    dispatch_valid       = 1'b1;
    dispatch_op          = o;
    dispatch_instruction = ins;
    dispatch_pc          = p;
    dispatch_imm         = im;
    dispatch_qj_busy     = qjb;
    dispatch_qj          = qjt;
    dispatch_vj          = vjv;
    dispatch_qk_busy     = qkb;
    dispatch_qk          = qkt;
    dispatch_vk          = vkv;
    dispatch_entry       = ent;
  endtask

  initial begin
    rst_in = 1'b1;
    rdy_in = 1'b1;
    idleInputs();
    alu_result = '0; alu_entry = '0; lsb_result = '0; lsb_entry = '0;
    applyStimulus(OP_ADDI, 32'h1234, 32'h40, 32'd1, 1'b0, 4'd0, 32'd1,
                  1'b0, 4'd0, 32'd2, 4'd9);
    tick();
    tick();
    rst_in = 1'b0;
    idleInputs();

    checkOutput("reset_new_calculate", 32'(new_calculate), 32'd0);
    checkOutput("reset_rs_full", 32'(rs_full), 32'd0);
    checkOutput("reset_op", 32'(op), 32'd0);
    checkOutput("reset_instruction", instruction, 32'd0);
    checkOutput("reset_vj", vj, 32'd0);
    checkOutput("reset_vk", vk, 32'd0);
    checkOutput("reset_pc", pc, 32'd0);
    checkOutput("reset_imm", imm, 32'd0);
    checkOutput("reset_entry", 32'(entry), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("reset_no_issue", 32'(new_calculate), 32'd0);
    end

    // Ready dispatch: ADDI vj=5 imm=7 entry=3.
    applyStimulus(OP_ADDI, 32'h00700293, 32'h100, 32'd7, 1'b0, 4'd0, 32'd5,
                  1'b0, 4'd0, 32'd0, 4'd3);
    tick();
    idleInputs();
    checkOutput("ready_not_same_cycle", 32'(new_calculate), 32'd0);
    tick();
    checkOutput("ready_new_calculate", 32'(new_calculate), 32'd1);
    checkOutput("ready_op", 32'(op), 32'(OP_ADDI));
    checkOutput("ready_vj", vj, 32'd5);
    checkOutput("ready_imm", imm, 32'd7);
    checkOutput("ready_entry", 32'(entry), 32'd3);
    checkOutput("ready_pc", pc, 32'h100);
    checkOutput("ready_instruction", instruction, 32'h00700293);
    tick();
    checkOutput("ready_pulse_drops", 32'(new_calculate), 32'd0);
    checkOutput("ready_vj_held", vj, 32'd5);

    // Wakeup via LSB bus two cycles after dispatch; ALU tag 3 must not wake it.
    applyStimulus(OP_ADD, 32'h00208033, 32'h104, 32'd0, 1'b1, 4'd2, 32'hdead,
                  1'b0, 4'd0, 32'd10, 4'd4);
    tick();
    idleInputs();
    checkOutput("wake_wait0", 32'(new_calculate), 32'd0);
    alu_broadcast = 1'b1; alu_entry = 4'd3; alu_result = 32'hbad;
    tick();
    idleInputs();
    checkOutput("wake_wait1", 32'(new_calculate), 32'd0);
    lsb_broadcast = 1'b1; lsb_entry = 4'd2; lsb_result = 32'h20;
    tick();
    idleInputs();
    checkOutput("wake_wait2", 32'(new_calculate), 32'd0);
    tick();
    checkOutput("wake_new_calculate", 32'(new_calculate), 32'd1);
    checkOutput("wake_vj", vj, 32'h20);
    checkOutput("wake_vk", vk, 32'd10);
    checkOutput("wake_entry", 32'(entry), 32'd4);

    // Dispatch-time forwarding from the ALU bus.
    applyStimulus(OP_SUB, 32'h40000033, 32'h108, 32'd0, 1'b0, 4'd0, 32'd1,
                  1'b1, 4'd6, 32'hdead, 4'd5);
    alu_broadcast = 1'b1; alu_entry = 4'd6; alu_result = 32'd9;
    tick();
    idleInputs();
    checkOutput("fwd_not_same_cycle", 32'(new_calculate), 32'd0);
    tick();
    checkOutput("fwd_new_calculate", 32'(new_calculate), 32'd1);
    checkOutput("fwd_vk", vk, 32'd9);
    checkOutput("fwd_vj", vj, 32'd1);
    checkOutput("fwd_entry", 32'(entry), 32'd5);

    // Both buses carry the same tag: ALU value wins.
    applyStimulus(OP_OR, 32'h0, 32'h10c, 32'd0, 1'b1, 4'd7, 32'd0,
                  1'b0, 4'd0, 32'd3, 4'd8);
    tick();
    idleInputs();
    alu_broadcast = 1'b1; alu_entry = 4'd7; alu_result = 32'ha;
    lsb_broadcast = 1'b1; lsb_entry = 4'd7; lsb_result = 32'hb;
    tick();
    idleInputs();
    tick();
    checkOutput("both_bus_new_calculate", 32'(new_calculate), 32'd1);
    checkOutput("both_bus_alu_wins", vj, 32'ha);

    // rdy_in low: dispatch ignored, outputs hold.
    applyStimulus(OP_AND, 32'h0, 32'h200, 32'd0, 1'b0, 4'd0, 32'd11,
                  1'b0, 4'd0, 32'd0, 4'hA);
    tick();
    applyStimulus(OP_AND, 32'h0, 32'h204, 32'd0, 1'b0, 4'd0, 32'd12,
                  1'b0, 4'd0, 32'd0, 4'hB);
    rdy_in = 1'b0;
    tick();
    checkOutput("stall_nc_held_low", 32'(new_calculate), 32'd0);
    rdy_in = 1'b1;
    idleInputs();
    tick();
    checkOutput("stall_issue", 32'(new_calculate), 32'd1);
    checkOutput("stall_issue_entry", 32'(entry), 32'hA);
    rdy_in = 1'b0;
    tick();
    checkOutput("stall_nc_held_high", 32'(new_calculate), 32'd1);
    checkOutput("stall_entry_held", 32'(entry), 32'hA);
    rdy_in = 1'b1;
    tick();
    checkOutput("stall_dispatch_ignored", 32'(new_calculate), 32'd0);

    // Fill all 16 slots pending on tag 1, then release them together.
    for (int i = 0; i < RS_SIZE; i++) begin
      checkOutput("fill_not_full", 32'(rs_full), 32'd0);
      applyStimulus(OP_ADD, 32'h0, 32'h300 + 32'(i * 4), 32'd0, 1'b1, 4'd1, 32'd0,
                    1'b0, 4'd0, 32'(i), 4'(i));
      tick();
    end
    idleInputs();
    checkOutput("fill_rs_full", 32'(rs_full), 32'd1);
    checkOutput("fill_no_issue", 32'(new_calculate), 32'd0);
    alu_broadcast = 1'b1; alu_entry = 4'd1; alu_result = 32'h55;
    tick();
    idleInputs();
    checkOutput("release_wait", 32'(new_calculate), 32'd0);
    for (int i = 0; i < RS_SIZE; i++) begin
      tick();
      checkOutput("order_new_calculate", 32'(new_calculate), 32'd1);
      checkOutput("order_entry", 32'(entry), 32'(i));
      checkOutput("order_vk", vk, 32'(i));
      checkOutput("order_vj", vj, 32'h55);
      if (i == 0) checkOutput("full_drops", 32'(rs_full), 32'd0);
    end
    tick();
    checkOutput("order_drained", 32'(new_calculate), 32'd0);

    // Flush: three pending slots plus one about to issue, clear with dispatch.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(OP_XOR, 32'h0, 32'h400, 32'd0, 1'b1, 4'd9, 32'd0,
                    1'b0, 4'd0, 32'd0, 4'(i));
      tick();
    end
    applyStimulus(OP_XOR, 32'h0, 32'h40c, 32'd0, 1'b0, 4'd0, 32'd1,
                  1'b0, 4'd0, 32'd2, 4'd12);
    tick();
    applyStimulus(OP_XOR, 32'h0, 32'h410, 32'd0, 1'b0, 4'd0, 32'd3,
                  1'b0, 4'd0, 32'd4, 4'd13);
    clear = 1'b1;
    tick();
    idleInputs();
    checkOutput("flush_new_calculate", 32'(new_calculate), 32'd0);
    checkOutput("flush_rs_full", 32'(rs_full), 32'd0);
    alu_broadcast = 1'b1; alu_entry = 4'd9; alu_result = 32'h77;
    tick();
    idleInputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("flush_no_issue", 32'(new_calculate), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
